// File: rtl/axil_reg_slave_if.sv
// AXI4-Lite bus bundle for axil_reg_slave: five channels, with slave and master views.
interface axil_reg_slave_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axil_reg_slave.sv
// AXI4-Lite register file with independent write and read FSMs.
// Define AXIL_REG_SLVERR_EN to answer out-of-range accesses with SLVERR instead of OKAY.
module axil_reg_slave #(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 12,
    parameter int                NUM_REGS = 16,
    parameter logic [DATA_W-1:0] RST_VAL  = '0
) (
    input  logic                       sys_clk,
    input  logic                       sys_rst,
    axil_reg_slave_if.slave            bus,
    output logic [NUM_REGS*DATA_W-1:0] reg_q,
    output logic [NUM_REGS-1:0]        wr_pulse
);
    localparam int STRB_W = DATA_W / 8;
    localparam int LSB    = $clog2(STRB_W);
    localparam int IDX_W  = ADDR_W - LSB;
    localparam logic [IDX_W:0] NREG = (IDX_W+1)'(NUM_REGS);
    localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef AXIL_REG_SLVERR_EN
    localparam logic [1:0] RESP_OOR  = 2'b10;
`else
    localparam logic [1:0] RESP_OOR  = 2'b00;
`endif

    typedef enum logic [1:0] {W_IDLE, W_AW, W_W, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_RESP}            r_state_t;

    w_state_t w_state, w_next;
    r_state_t r_state, r_next;

    logic [NUM_REGS-1:0][DATA_W-1:0] regs;
    logic [ADDR_W-1:0] aw_q;
    logic [DATA_W-1:0] wd_q;
    logic [STRB_W-1:0] ws_q;
    logic              in_rst;
    logic              aw_hs, w_hs, ar_hs, commit;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_data;
    logic [STRB_W-1:0] c_strb;
    logic [IDX_W-1:0]  c_idx, r_idx;
    logic              c_in, r_in;
    logic [DATA_W-1:0] rd_val;
    logic [1:0]        bresp_q, rresp_q;
    logic [DATA_W-1:0] rdata_q;
    logic              unused_ok;

    assign reg_q     = regs;
    assign bus.bresp = bresp_q;
    assign bus.rresp = rresp_q;
    assign bus.rdata = rdata_q;

    // The second half of a write may come straight from the bus or from the captured copy.
    assign c_addr = (w_state == W_AW) ? aw_q : bus.awaddr;
    assign c_data = (w_state == W_W)  ? wd_q : bus.wdata;
    assign c_strb = (w_state == W_W)  ? ws_q : bus.wstrb;
    assign c_idx  = c_addr[ADDR_W-1:LSB];
    assign r_idx  = bus.araddr[ADDR_W-1:LSB];
    assign c_in   = {1'b0, c_idx} < NREG;
    assign r_in   = {1'b0, r_idx} < NREG;
    assign unused_ok = ^{c_addr[LSB-1:0], bus.araddr[LSB-1:0]};

    // in_rst holds the readies low for the cycle right after a reset edge.
    always_comb begin
        w_next      = w_state;
        bus.awready = 1'b0;
        bus.wready  = 1'b0;
        bus.bvalid  = 1'b0;
        commit      = 1'b0;
        case (w_state)
            W_IDLE: begin
                bus.awready = ~in_rst;
                bus.wready  = ~in_rst;
            end
            W_AW:   bus.wready  = 1'b1;
            W_W:    bus.awready = 1'b1;
            W_RESP: bus.bvalid  = 1'b1;
            default: ;
        endcase
        aw_hs = bus.awvalid && bus.awready;
        w_hs  = bus.wvalid  && bus.wready;
        case (w_state)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    commit = 1'b1;
                    w_next = W_RESP;
                end else if (aw_hs) begin
                    w_next = W_AW;
                end else if (w_hs) begin
                    w_next = W_W;
                end
            end
            W_AW: if (w_hs) begin
                commit = 1'b1;
                w_next = W_RESP;
            end
            W_W: if (aw_hs) begin
                commit = 1'b1;
                w_next = W_RESP;
            end
            W_RESP: if (bus.bready) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    always_comb begin
        r_next      = r_state;
        bus.arready = (r_state == R_IDLE) && !in_rst;
        bus.rvalid  = (r_state == R_RESP);
        ar_hs       = bus.arvalid && bus.arready;
        if (ar_hs) r_next = R_RESP;
        else if (r_state == R_RESP && bus.rready) r_next = R_IDLE;
    end

    always_comb begin
        rd_val = '0;
        for (int i = 0; i < NUM_REGS; i++)
            if (r_idx == IDX_W'(i)) rd_val = regs[i];
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            w_state  <= W_IDLE;
            r_state  <= R_IDLE;
            in_rst   <= 1'b1;
            aw_q     <= '0;
            wd_q     <= '0;
            ws_q     <= '0;
            bresp_q  <= '0;
            rresp_q  <= '0;
            rdata_q  <= '0;
            wr_pulse <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= RST_VAL;
        end else begin
            w_state  <= w_next;
            r_state  <= r_next;
            in_rst   <= 1'b0;
            wr_pulse <= '0;
            if (aw_hs) aw_q <= bus.awaddr;
            if (w_hs) begin
                wd_q <= bus.wdata;
                ws_q <= bus.wstrb;
            end
            if (commit) begin
                bresp_q <= c_in ? RESP_OKAY : RESP_OOR;
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (c_in && c_idx == IDX_W'(i)) begin
                        wr_pulse[i] <= 1'b1;
                        for (int b = 0; b < STRB_W; b++)
                            if (c_strb[b]) regs[i][b*8 +: 8] <= c_data[b*8 +: 8];
                    end
                end
            end
            // Reads sample regs before this edge's commit lands, giving pre-write data.
            if (ar_hs) begin
                rdata_q <= rd_val;
                rresp_q <= r_in ? RESP_OKAY : RESP_OOR;
            end
        end
    end
endmodule

// File: tb/tb_axil_reg_slave.sv
// Self-checking bench for axil_reg_slave: vector table, directed corner cases, random ops vs. array model.
module tb_axil_reg_slave;
    localparam logic [1:0] OKAY = 2'b00;
`ifdef AXIL_REG_SLVERR_EN
    localparam logic [1:0] OOR = 2'b10;
`else
    localparam logic [1:0] OOR = 2'b00;
`endif

    logic          sys_clk = 1'b0;
    logic          sys_rst;
    logic [511:0]  reg_q;
    logic [15:0]   wr_pulse;
    int            checks = 0;
    int            passes = 0;
    logic [31:0]   model [16];

    axil_reg_slave_if #(.ADDR_W(12), .DATA_W(32)) bus();

    axil_reg_slave dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (bus),
        .reg_q   (reg_q),
        .wr_pulse(wr_pulse)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [1:0]  bresp;
        logic [15:0] pulse;
        logic [31:0] rdata;
        logic [1:0]  rresp;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic timeout(input string name);
        checks++;
        $display("FAIL %s: handshake never completed", name);
    endtask

    task automatic axi_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int aw_dly, input int w_dly, input int b_dly,
                             input logic [1:0] exp_resp, input logic [15:0] exp_pulse);
        bit aw_done, w_done, aw_now, w_now;
        int cyc;
        aw_done = 0; w_done = 0; cyc = 0;
        bus.awaddr = a; bus.wdata = d; bus.wstrb = s;
        while (!(aw_done && w_done)) begin
            bus.awvalid = !aw_done && cyc >= aw_dly;
            bus.wvalid  = !w_done  && cyc >= w_dly;
            @(negedge sys_clk);
            aw_now = bus.awvalid && bus.awready;
            w_now  = bus.wvalid  && bus.wready;
            @(posedge sys_clk); #1;
            aw_done |= aw_now;
            w_done  |= w_now;
            cyc++;
            if (aw_done && !w_done)      chk("ready_in_w_aw", {bus.awready, bus.wready}, 2'b01);
            else if (w_done && !aw_done) chk("ready_in_w_w",  {bus.awready, bus.wready}, 2'b10);
            if (cyc > 40) begin
                timeout("write_timeout");
                break;
            end
        end
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        chk("bvalid_latency", bus.bvalid, 1'b1);
        chk("bresp", bus.bresp, exp_resp);
        chk("wr_pulse", wr_pulse, exp_pulse);
        for (int k = 0; k < b_dly; k++) begin
            @(posedge sys_clk); #1;
            chk("bvalid_hold", bus.bvalid, 1'b1);
            chk("bresp_hold", bus.bresp, exp_resp);
            chk("ready_in_resp", {bus.awready, bus.wready}, 2'b00);
        end
        bus.bready = 1'b1;
        @(posedge sys_clk); #1;
        bus.bready = 1'b0;
        chk("bvalid_drop", bus.bvalid, 1'b0);
        chk("wr_pulse_clear", wr_pulse, 16'h0);
    endtask

    task automatic axi_read(input logic [11:0] a, input int r_dly,
                            input logic [31:0] exp_data, input logic [1:0] exp_resp);
        bit hs;
        int cyc;
        hs = 0; cyc = 0;
        bus.araddr = a;
        bus.arvalid = 1'b1;
        while (!hs) begin
            @(negedge sys_clk);
            hs = bus.arready;
            @(posedge sys_clk); #1;
            if (++cyc > 40) begin
                timeout("read_timeout");
                break;
            end
        end
        bus.arvalid = 1'b0;
        chk("rvalid_latency", bus.rvalid, 1'b1);
        chk("rdata", bus.rdata, exp_data);
        chk("rresp", bus.rresp, exp_resp);
        for (int k = 0; k < r_dly; k++) begin
            @(posedge sys_clk); #1;
            chk("rdata_hold", {bus.rvalid, bus.arready, bus.rresp, bus.rdata},
                {1'b1, 1'b0, exp_resp, exp_data});
        end
        bus.rready = 1'b1;
        @(posedge sys_clk); #1;
        bus.rready = 1'b0;
        chk("rvalid_drop", bus.rvalid, 1'b0);
    endtask

    task automatic check_all_regs(input string name);
        for (int i = 0; i < 16; i++) chk(name, reg_q[i*32 +: 32], model[i]);
    endtask

    vec_t vecs [7];

    initial begin
        vecs[0] = '{12'h004, 32'hDEADBEEF, 4'hF, OKAY, 16'h0002, 32'hDEADBEEF, OKAY};
        vecs[1] = '{12'h008, 32'h11223344, 4'hF, OKAY, 16'h0004, 32'h11223344, OKAY};
        vecs[2] = '{12'h006, 32'h0000CAFE, 4'h3, OKAY, 16'h0002, 32'hDEADCAFE, OKAY};
        vecs[3] = '{12'h03C, 32'hFFFFFFFF, 4'h0, OKAY, 16'h8000, 32'h00000000, OKAY};
        vecs[4] = '{12'h040, 32'h12345678, 4'hF, OOR,  16'h0000, 32'h00000000, OOR};
        vecs[5] = '{12'h03F, 32'hA5A5A5A5, 4'hC, OKAY, 16'h8000, 32'hA5A50000, OKAY};
        vecs[6] = '{12'hFFC, 32'h01020304, 4'hF, OOR,  16'h0000, 32'h00000000, OOR};

        bus.awaddr = '0; bus.awvalid = 0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 0;
        bus.bready = 0; bus.araddr = '0; bus.arvalid = 0; bus.rready = 0;
        sys_rst = 1'b1;
        repeat (3) @(posedge sys_clk);
        #1;
        chk("rst_ready", {bus.awready, bus.wready, bus.arready}, 3'b000);
        chk("rst_valid", {bus.bvalid, bus.rvalid}, 2'b00);
        chk("rst_outputs", {bus.bresp, bus.rresp, bus.rdata, wr_pulse}, '0);
        chk("rst_regs_lo", reg_q[63:0], 64'h0);
        sys_rst = 1'b0;
        @(posedge sys_clk); #1;
        chk("idle_ready", {bus.awready, bus.wready, bus.arready}, 3'b111);

        for (int i = 0; i < 7; i++) begin
            axi_write(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb,
                      (i % 3 == 1) ? 1 : 0, (i % 3 == 2) ? 1 : 0, i % 2,
                      vecs[i].bresp, vecs[i].pulse);
            axi_read(vecs[i].addr, i % 3, vecs[i].rdata, vecs[i].rresp);
        end

        // W three cycles ahead of AW, byte 0 only
        axi_write(12'h008, 32'h000000AA, 4'h1, 3, 0, 0, OKAY, 16'h0004);
        chk("reg2_strb", reg_q[95:64], 32'h112233AA);

        // bready held off for five cycles
        axi_write(12'h010, 32'h0BADF00D, 4'hF, 0, 0, 5, OKAY, 16'h0010);

        // write commit and read of the same register on one edge
        bus.awaddr = 12'h00C; bus.wdata = 32'h55; bus.wstrb = 4'hF; bus.araddr = 12'h00C;
        bus.awvalid = 1; bus.wvalid = 1; bus.arvalid = 1;
        @(negedge sys_clk);
        chk("rw_ready", {bus.awready, bus.wready, bus.arready}, 3'b111);
        @(posedge sys_clk); #1;
        bus.awvalid = 0; bus.wvalid = 0; bus.arvalid = 0;
        chk("rw_old_data", {bus.rvalid, bus.rresp, bus.rdata}, {1'b1, OKAY, 32'h0});
        chk("rw_commit", {bus.bvalid, reg_q[127:96]}, {1'b1, 32'h55});
        bus.bready = 1; bus.rready = 1;
        @(posedge sys_clk); #1;
        bus.bready = 0; bus.rready = 0;
        chk("rw_done", {bus.bvalid, bus.rvalid}, 2'b00);
        axi_read(12'h00C, 0, 32'h55, OKAY);

        foreach (model[i]) model[i] = 32'h0;
        model[1] = 32'hDEADCAFE; model[2] = 32'h112233AA; model[3] = 32'h55;
        model[4] = 32'h0BADF00D; model[15] = 32'hA5A50000;
        check_all_regs("regs_after_directed");

        // reset while holding a captured AW
        bus.awaddr = 12'h014; bus.awvalid = 1;
        @(posedge sys_clk); #1;
        bus.awvalid = 0;
        chk("in_w_aw", {bus.awready, bus.wready}, 2'b01);
        sys_rst = 1'b1;
        @(posedge sys_clk); #1;
        chk("mid_rst_ready", {bus.awready, bus.wready, bus.bvalid, wr_pulse}, '0);
        sys_rst = 1'b0;
        @(posedge sys_clk); #1;
        chk("post_rst_ready", {bus.awready, bus.wready, bus.bvalid}, 3'b110);
        foreach (model[i]) model[i] = 32'h0;
        check_all_regs("regs_after_reset");

        // random traffic against the array model
        for (int n = 0; n < 80; n++) begin
            int          idx;
            logic [11:0] a;
            logic [31:0] d;
            logic [3:0]  s;
            idx = $urandom_range(0, 17);
            a   = 12'(idx * 4 + $urandom_range(0, 3));
            d   = $urandom;
            s   = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
                if (idx < 16) begin
                    for (int b = 0; b < 4; b++)
                        if (s[b]) model[idx][b*8 +: 8] = d[b*8 +: 8];
                    axi_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3),
                              $urandom_range(0, 2), OKAY, 16'(1 << idx));
                end else begin
                    axi_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3),
                              $urandom_range(0, 2), OOR, 16'h0);
                end
            end else begin
                axi_read(a, $urandom_range(0, 2), (idx < 16) ? model[idx] : 32'h0,
                         (idx < 16) ? OKAY : OOR);
            end
        end
        check_all_regs("regs_after_random");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/axil_reg_slave.md
AXIL_REG_SLAVE -- requirements
Module: axil_reg_slave

Interface
REQ-001 SHALL have parameter DATA_W, default 32, bus data width; legal values are 32 and 64.
REQ-002 SHALL have parameter ADDR_W, default 12, byte-address width.
REQ-003 SHALL have parameter NUM_REGS, default 16, register count; legal range is 1..2^(ADDR_W-log2(DATA_W/8)).
REQ-004 SHALL have parameter RST_VAL, default 0, reset value of every register, DATA_W wide.
REQ-005 SHALL have one clock; reset is synchronous and active-high.
REQ-006 sys_clk  in  1  sole clock, rising edge.
REQ-007 sys_rst  in  1  synchronous active-high reset.
REQ-008 awaddr in ADDR_W; awvalid in 1; awready out 1: AXI4-Lite write-address channel.
REQ-009 wdata in DATA_W; wstrb in DATA_W/8; wvalid in 1; wready out 1: write-data channel.
REQ-010 bresp out 2; bvalid out 1; bready in 1: write-response channel.
REQ-011 araddr in ADDR_W; arvalid in 1; arready out 1: read-address channel.
REQ-012 rdata out DATA_W; rresp out 2; rvalid out 1; rready in 1: read-data channel.
REQ-013 reg_q  out  NUM_REGS*DATA_W  flat register contents; register i is at bits [i*DATA_W +: DATA_W].
REQ-014 wr_pulse  out  NUM_REGS  one-cycle strobe per register, asserted on the cycle register i is written.

Function
REQ-015 Register index SHALL be addr[ADDR_W-1:log2(DATA_W/8)]; lower address bits SHALL be ignored.
REQ-016 An address SHALL be in range when index < NUM_REGS.
REQ-017 Write FSM states SHALL be W_IDLE, W_AW, W_W, and W_RESP.
- W_IDLE: awready=1, wready=1.
- W_AW: AW captured; awready=0, wready=1.
- W_W: W captured; awready=1, wready=0.
- W_RESP: awready=0, wready=0, bvalid=1.
REQ-018 AW and W SHALL be accepted in either order or in the same cycle.
REQ-019 The commit SHALL occur on the clock edge at which the second of AW/W handshakes.
- In-range commit: byte k of the register SHALL be updated only when wstrb[k]=1.
- wr_pulse[idx] SHALL be high for the cycle after the commit edge.
- The FSM SHALL move to W_RESP.
REQ-020 bvalid SHALL assert the cycle after the commit.
- W_RESP SHALL be held with bresp stable until bvalid && bready.
- The FSM SHALL then return to W_IDLE.
- Minimum write latency is one cycle from AW+W to bvalid.
REQ-021 Only one write SHALL be outstanding; no new AW/W SHALL be accepted while in W_RESP.
REQ-022 Read FSM states SHALL be R_IDLE (arready=1) and R_RESP (arready=0, rvalid=1).
REQ-023 On an arvalid && arready edge, rdata and rresp SHALL be registered and rvalid SHALL assert the next cycle; read latency is one cycle.
REQ-024 rdata/rresp SHALL be held stable in R_RESP until rvalid && rready; the FSM SHALL then return to R_IDLE.
REQ-025 Read and write FSMs SHALL be independent.
- A read handshake on the same edge as a write commit to the same register SHALL return the pre-write value.
REQ-026 An out-of-range write SHALL modify no register and SHALL assert no wr_pulse bit.
REQ-027 An out-of-range read SHALL return rdata=0.
REQ-028 An in-range access SHALL return resp=2'b00 (OKAY).
REQ-029 wstrb=0 on an in-range write SHALL leave the register unchanged, still pulse wr_pulse, and return OKAY.

Reset
REQ-030 While sys_rst=1 at a clock edge, the following SHALL be cleared:
- Both FSMs go to IDLE.
- Every register is loaded with RST_VAL.
- awready=0, wready=0, arready=0, bvalid=0, rvalid=0.
- bresp=0, rresp=0, rdata=0, wr_pulse=0.
REQ-031 In the first cycle after reset deasserts, the IDLE ready values SHALL apply.
REQ-032 Reset mid-transaction SHALL discard any captured AW/W/AR and any pending response without a commit.

Configuration
REQ-033 Macro AXIL_REG_SLVERR_EN SHALL select the out-of-range response.
- Defined: out-of-range writes and reads return resp=2'b10 (SLVERR).
- Undefined: they return 2'b00 (OKAY); REQ-026 and REQ-027 behaviour is unchanged.

Verification
REQ-034 Reset release, then AW 0x004 and W 0xDEADBEEF (wstrb=0xF) in the same cycle -> bvalid next cycle, bresp=00, reg_q[63:32]=0xDEADBEEF, wr_pulse=0x0002 for one cycle.
REQ-035 W 0x000000AA (wstrb=0x1) three cycles before AW 0x008, with reg 2 = 0x11223344 -> reg 2 = 0x112233AA; awready=1 and wready=0 while in W_W.
REQ-036 Write commit to reg 3 (0x55) on the same edge as an AR to 0x00C, with old value 0x0 -> rdata=0x0 and rresp=00; a subsequent read returns 0x55.
REQ-037 Read 0x040 with NUM_REGS=16 -> rdata=0; rresp=10 with AXIL_REG_SLVERR_EN defined, 00 without; no register changes.
REQ-038 bready held low for 5 cycles -> bvalid and bresp stable throughout; awready=0 and wready=0 until the handshake.
REQ-039 sys_rst pulsed while in W_AW -> no commit, all registers = RST_VAL, awready=1 and wready=1 in the next cycle.
